// File: rtl/arithmetic_unit_if.sv
// Operand/opcode/result bundle for arithmetic_unit; the opcode source
// drives through master, the datapath sits on slave.
interface arithmetic_unit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       opcode;
  logic             res_en;
  logic [1:0]       op_select;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] q;
  logic             carry;
  logic             zero;
  logic             dz;

  modport master (
    output a, b, opcode, res_en,
    input  op_select, result, q, carry, zero, dz
  );

  modport slave (
    input  a, b, opcode, res_en,
    output op_select, result, q, carry, zero, dz
  );
endinterface

// File: rtl/arithmetic_unit.sv
// Single-cycle add/sub/div/mul datapath with gated, registered output.
// Flag logic (carry/zero/dz) is built only with ARITHMETIC_UNIT_FLAGS_EN.
module arithmetic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  arithmetic_unit_if.slave io
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] add_r, sub_r, mul_r, quo, res_raw, q_d, q_q;
  logic             div_by_zero;

  assign op           = op_e'(io.opcode);
  assign io.op_select = io.opcode;
  assign div_by_zero  = (io.b == '0);

  // Restoring divider unrolled over WIDTH stages, MSB first; the remainder
  // of stage 0 is never needed, so only stages WIDTH-1..1 carry one out.
  logic [WIDTH-1:1][WIDTH-1:0] rem_stg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_div
    logic [WIDTH:0] sh;
    logic           ge;
    if (i == WIDTH-1) begin : g_first
      assign sh = {{WIDTH{1'b0}}, io.a[i]};
    end else begin : g_next
      assign sh = {rem_stg[i+1], io.a[i]};
    end
    assign ge     = (sh >= {1'b0, io.b});
    assign quo[i] = ge;
    if (i > 0) begin : g_rem
      assign rem_stg[i] = ge ? WIDTH'(sh - {1'b0, io.b}) : sh[WIDTH-1:0];
    end
  end

`ifdef ARITHMETIC_UNIT_FLAGS_EN
  logic [WIDTH:0]     sum_w, dif_w;
  logic [2*WIDTH-1:0] prod_w;
  logic               cy_raw, dz_raw;
  logic               carry_d, zero_d, dz_d;
  logic               carry_q, zero_q, dz_q;

  assign sum_w  = {1'b0, io.a} + {1'b0, io.b};
  assign dif_w  = {1'b0, io.a} - {1'b0, io.b};
  assign prod_w = {{WIDTH{1'b0}}, io.a} * {{WIDTH{1'b0}}, io.b};
  assign add_r  = sum_w[WIDTH-1:0];
  assign sub_r  = dif_w[WIDTH-1:0];
  assign mul_r  = prod_w[WIDTH-1:0];

  // Top bit of the 9-bit difference is the borrow (a < b).
  always_comb begin
    cy_raw = 1'b0;
    dz_raw = 1'b0;
    unique case (op)
      OP_ADD: cy_raw = sum_w[WIDTH];
      OP_SUB: cy_raw = dif_w[WIDTH];
      OP_DIV: dz_raw = div_by_zero;
      OP_MUL: cy_raw = |prod_w[2*WIDTH-1:WIDTH];
    endcase
  end
`else
  assign add_r = io.a + io.b;
  assign sub_r = io.a - io.b;
  assign mul_r = io.a * io.b;
`endif

  always_comb begin
    res_raw = '0;
    unique case (op)
      OP_ADD: res_raw = add_r;
      OP_SUB: res_raw = sub_r;
      OP_DIV: res_raw = div_by_zero ? '1 : quo;
      OP_MUL: res_raw = mul_r;
    endcase
  end

  assign io.result = res_raw;

  always_comb begin
    q_d = io.res_en ? res_raw : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign io.q = q_q;

`ifdef ARITHMETIC_UNIT_FLAGS_EN
  // Gated result never reports carry/dz; zero follows the gated value.
  always_comb begin
    carry_d = io.res_en & cy_raw;
    dz_d    = io.res_en & dz_raw;
    zero_d  = (q_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
    end
  end

  assign io.carry = carry_q;
  assign io.zero  = zero_q;
  assign io.dz    = dz_q;
`else
  assign io.carry = 1'b0;
  assign io.zero  = 1'b0;
  assign io.dz    = 1'b0;
`endif

endmodule

// File: tb/tb_arithmetic_unit.sv
// Bench for arithmetic_unit: directed corner tables plus random back-to-back
// ops against an integer-arithmetic reference model.
module tb_arithmetic_unit;

`ifdef ARITHMETIC_UNIT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  arithmetic_unit_if #(.WIDTH(8)) bus ();

  arithmetic_unit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  function automatic void model(input int a, input int b, input int op, input bit en,
                                output logic [7:0] res, output logic [10:0] regs);
    int  full;
    int  qv;
    bit  rc, rd, c, z, d;
    rc = 1'b0; rd = 1'b0; full = 0;
    case (op)
      0: begin full = a + b; res = 8'(full % 256); rc = (full > 255); end
      1: begin res = 8'((a - b + 256) % 256); rc = (a < b); end
      2: begin
        if (b == 0) begin res = 8'd255; rd = 1'b1; end
        else res = 8'(a / b);
      end
      default: begin full = a * b; res = 8'(full % 256); rc = (full > 255); end
    endcase
    qv = en ? int'(res) : 0;
    c = FLAGS && en && rc;
    d = FLAGS && en && rd;
    z = FLAGS && (qv == 0);
    regs = {8'(qv), c, z, d};
  endfunction

  task automatic drive(input int a, input int b, input int op, input bit en);
    bus.a      = 8'(a);
    bus.b      = 8'(b);
    bus.opcode = 2'(op);
    bus.res_en = en;
  endtask

  task automatic test_reset();
    logic [7:0]  er;
    logic [10:0] ex;
    drive($urandom_range(255), $urandom_range(255), $urandom_range(3), 1'b1);
    #1 rst = 1'b0;
    #2;
    total++;
    if ({bus.q, bus.carry, bus.zero, bus.dz} !== 11'd0)
      $display("FAIL reset_async: got q=%0d c=%0b z=%0b dz=%0b, want all 0",
               bus.q, bus.carry, bus.zero, bus.dz);
    if ({bus.q, bus.carry, bus.zero, bus.dz} !== 11'd0) bad++;
    for (int i = 0; i < 3; i++) begin
      #4 drive($urandom_range(255), $urandom_range(255), $urandom_range(3), 1'b1);
    end
    #1;
    total++;
    if ({bus.q, bus.carry, bus.zero, bus.dz} !== 11'd0) begin
      bad++;
      $display("FAIL reset_held: got q=%0d c=%0b z=%0b dz=%0b, want all 0",
               bus.q, bus.carry, bus.zero, bus.dz);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(5, 3, 0, 1'b1);
    model(5, 3, 0, 1'b1, er, ex);
    @(posedge clk); #1;
    total++;
    if ({bus.q, bus.carry, bus.zero, bus.dz} !== ex) begin
      bad++;
      $display("FAIL reset_first_add: got q=%0d c=%0b z=%0b dz=%0b, want q=%0d c=%0b z=%0b dz=%0b",
               bus.q, bus.carry, bus.zero, bus.dz, ex[10:3], ex[2], ex[1], ex[0]);
    end
    total++;
    if (bus.q !== 8'd8) begin
      bad++;
      $display("FAIL reset_first_q: got %0d want 8", bus.q);
    end
  endtask

  task automatic test_basic();
    int ta[3] = '{8, 40, 6};
    int tb[3] = '{3, 8, 7};
    int to[3] = '{1, 2, 3};
    int tq[3] = '{5, 5, 42};
    logic [7:0]  er;
    logic [10:0] ex;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i], to[i], 1'b1);
      model(ta[i], tb[i], to[i], 1'b1, er, ex);
      #1;
      total++;
      if (bus.op_select !== 2'(to[i])) begin
        bad++;
        $display("FAIL basic_op_select[%0d]: got %0d want %0d", i, bus.op_select, to[i]);
      end
      total++;
      if (bus.result !== 8'(tq[i])) begin
        bad++;
        $display("FAIL basic_result[%0d]: got %0d want %0d", i, bus.result, tq[i]);
      end
      @(posedge clk); #1;
      total++;
      if ({bus.q, bus.carry, bus.zero, bus.dz} !== ex) begin
        bad++;
        $display("FAIL basic_reg[%0d]: got q=%0d c=%0b z=%0b dz=%0b, want q=%0d c=%0b z=%0b dz=%0b",
                 i, bus.q, bus.carry, bus.zero, bus.dz, ex[10:3], ex[2], ex[1], ex[0]);
      end
    end
  endtask

  task automatic test_overflow();
    int ta[4] = '{200, 3, 20, 255};
    int tb[4] = '{100, 5, 20, 1};
    int to[4] = '{0, 1, 3, 0};
    int tq[4] = '{44, 254, 144, 0};
    logic [7:0]  er;
    logic [10:0] ex;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i], to[i], 1'b1);
      model(ta[i], tb[i], to[i], 1'b1, er, ex);
      @(posedge clk); #1;
      total++;
      if (bus.q !== 8'(tq[i])) begin
        bad++;
        $display("FAIL ovf_q[%0d]: got %0d want %0d", i, bus.q, tq[i]);
      end
      total++;
      if ({bus.carry, bus.zero, bus.dz} !== ex[2:0]) begin
        bad++;
        $display("FAIL ovf_flags[%0d]: got c=%0b z=%0b dz=%0b, want c=%0b z=%0b dz=%0b",
                 i, bus.carry, bus.zero, bus.dz, ex[2], ex[1], ex[0]);
      end
    end
  endtask

  task automatic test_div_edges();
    int ta[3] = '{7, 7, 255};
    int tb[3] = '{0, 9, 1};
    int tq[3] = '{255, 0, 255};
    logic [7:0]  er;
    logic [10:0] ex;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i], 2, 1'b1);
      model(ta[i], tb[i], 2, 1'b1, er, ex);
      #1;
      total++;
      if (bus.result !== 8'(tq[i])) begin
        bad++;
        $display("FAIL div_result[%0d]: got %0d want %0d", i, bus.result, tq[i]);
      end
      @(posedge clk); #1;
      total++;
      if ({bus.q, bus.carry, bus.zero, bus.dz} !== ex) begin
        bad++;
        $display("FAIL div_reg[%0d]: got q=%0d c=%0b z=%0b dz=%0b, want q=%0d c=%0b z=%0b dz=%0b",
                 i, bus.q, bus.carry, bus.zero, bus.dz, ex[10:3], ex[2], ex[1], ex[0]);
      end
    end
  endtask

  task automatic test_gating();
    logic [7:0]  er;
    logic [10:0] ex;
    @(negedge clk);
    drive(6, 7, 3, 1'b0);
    model(6, 7, 3, 1'b0, er, ex);
    #1;
    total++;
    if (bus.result !== 8'd42) begin
      bad++;
      $display("FAIL gate_result: got %0d want 42", bus.result);
    end
    @(posedge clk); #1;
    total++;
    if ({bus.q, bus.carry, bus.zero, bus.dz} !== ex) begin
      bad++;
      $display("FAIL gate_reg: got q=%0d c=%0b z=%0b dz=%0b, want q=%0d c=%0b z=%0b dz=%0b",
               bus.q, bus.carry, bus.zero, bus.dz, ex[10:3], ex[2], ex[1], ex[0]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(6, 7, 3, 1'b1);
    @(posedge clk); #1;
    total++;
    if (bus.q !== 8'd42) begin
      bad++;
      $display("FAIL arst_pre_q: got %0d want 42", bus.q);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bus.q, bus.carry, bus.zero, bus.dz} !== 11'd0) begin
      bad++;
      $display("FAIL arst_now: got q=%0d c=%0b z=%0b dz=%0b, want all 0",
               bus.q, bus.carry, bus.zero, bus.dz);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    int          a, b, op;
    bit          en;
    logic [7:0]  er;
    logic [10:0] ex;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a  = $urandom_range(255);
      b  = ($urandom_range(7) == 0) ? 0 : $urandom_range(255);
      op = $urandom_range(3);
      en = ($urandom_range(4) != 0);
      drive(a, b, op, en);
      model(a, b, op, en, er, ex);
      #1;
      total++;
      if (bus.result !== er) begin
        bad++;
        $display("FAIL rnd_result[%0d]: a=%0d b=%0d op=%0d got %0d want %0d",
                 i, a, b, op, bus.result, er);
      end
      total++;
      if (bus.op_select !== 2'(op)) begin
        bad++;
        $display("FAIL rnd_op_select[%0d]: got %0d want %0d", i, bus.op_select, op);
      end
      @(posedge clk); #1;
      total++;
      if ({bus.q, bus.carry, bus.zero, bus.dz} !== ex) begin
        bad++;
        $display("FAIL rnd_reg[%0d]: a=%0d b=%0d op=%0d en=%0b got q=%0d c=%0b z=%0b dz=%0b, want q=%0d c=%0b z=%0b dz=%0b",
                 i, a, b, op, en, bus.q, bus.carry, bus.zero, bus.dz,
                 ex[10:3], ex[2], ex[1], ex[0]);
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 1'b1);
    test_reset();
    test_basic();
    test_overflow();
    test_div_edges();
    test_gating();
    test_async_reset();
    test_overflow();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
